// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader: loads the fabric configuration from a 32-bit valid/ready
// word stream into the LUT truth tables and switch-box configure registers.
// Word order: two words per LUT (low 32 bits, then bit 32 in word[0]), then one
// word per switch box (low SB_BITS bits).
// Optional build macro CFG_CHECKSUM_EN: a trailing XOR checksum word is
// required; words land in shadow registers and are committed only on a match.
module cfg_stream_loader #(
  parameter int NUM_LUT  = 9,
  parameter int LUT_BITS = 33,
  parameter int NUM_SB   = 13,
  parameter int SB_BITS  = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [31:0]                  word_in,
  input  logic                         word_valid,
  output logic                         word_ready,
  output logic [NUM_LUT*LUT_BITS-1:0]  lut_cfg,
  output logic [NUM_SB*SB_BITS-1:0]    sb_cfg,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int MAX_N = (NUM_LUT > NUM_SB) ? NUM_LUT : NUM_SB;
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [IDX_W-1:0] LAST_LUT = IDX_W'(NUM_LUT - 1);
  localparam logic [IDX_W-1:0] LAST_SB  = IDX_W'(NUM_SB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LUT_LO = 3'd1,
    ST_LUT_HI = 3'd2,
    ST_SB     = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LUT_LO = 3'd1,
    ST_LUT_HI = 3'd2,
    ST_SB     = 3'd3,
    ST_DONE   = 3'd5
  } state_e;
`endif

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_LUT*LUT_BITS-1:0]   lut_cfg_q, lut_cfg_d;
  logic [NUM_SB*SB_BITS-1:0]     sb_cfg_q, sb_cfg_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          ready_q, ready_d;
  logic                          accept_s;

`ifdef CFG_CHECKSUM_EN
  logic [NUM_LUT*LUT_BITS-1:0]   shd_lut_q, shd_lut_d;
  logic [NUM_SB*SB_BITS-1:0]     shd_sb_q, shd_sb_d;
  logic [31:0]                   chk_q, chk_d;
  logic                          error_q, error_d;

  // Running XOR of every configuration word in the stream.
  function automatic logic [31:0] xor_accum(input logic [31:0] acc, input logic [31:0] w);
    return acc ^ w;
  endfunction
`endif

  assign accept_s = word_valid && ready_q;

  // State register plus all configuration and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lut_cfg_q <= '0;
      sb_cfg_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      shd_lut_q <= '0;
      shd_sb_q  <= '0;
      chk_q     <= 32'd0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lut_cfg_q <= lut_cfg_d;
      sb_cfg_q  <= sb_cfg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
`ifdef CFG_CHECKSUM_EN
      shd_lut_q <= shd_lut_d;
      shd_sb_q  <= shd_sb_d;
      chk_q     <= chk_d;
      error_q   <= error_d;
`endif
    end
  end

  // Next-state and datapath: one word is consumed per accepting edge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lut_cfg_d = lut_cfg_q;
    sb_cfg_d  = sb_cfg_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ready_d   = ready_q;
`ifdef CFG_CHECKSUM_EN
    shd_lut_d = shd_lut_q;
    shd_sb_d  = shd_sb_q;
    chk_d     = chk_q;
    error_d   = error_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LUT_LO;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ready_d = 1'b1;
`ifdef CFG_CHECKSUM_EN
          chk_d   = 32'd0;
          error_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LUT_LO: begin
        if (accept_s) begin
`ifdef CFG_CHECKSUM_EN
          shd_lut_d[int'(idx_q)*LUT_BITS +: 32] = word_in;
          chk_d = xor_accum(chk_q, word_in);
`else
          lut_cfg_d[int'(idx_q)*LUT_BITS +: 32] = word_in;
`endif
          state_d = ST_LUT_HI;
        end else begin
          state_d = ST_LUT_LO;
        end
      end

      ST_LUT_HI: begin
        if (accept_s) begin
`ifdef CFG_CHECKSUM_EN
          shd_lut_d[int'(idx_q)*LUT_BITS + 32] = word_in[0];
          chk_d = xor_accum(chk_q, word_in);
`else
          lut_cfg_d[int'(idx_q)*LUT_BITS + 32] = word_in[0];
`endif
          if (idx_q == LAST_LUT) begin
            idx_d   = '0;
            state_d = ST_SB;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_LUT_LO;
          end
        end else begin
          state_d = ST_LUT_HI;
        end
      end

      ST_SB: begin
        if (accept_s) begin
`ifdef CFG_CHECKSUM_EN
          shd_sb_d[int'(idx_q)*SB_BITS +: SB_BITS] = word_in[SB_BITS-1:0];
          chk_d = xor_accum(chk_q, word_in);
`else
          sb_cfg_d[int'(idx_q)*SB_BITS +: SB_BITS] = word_in[SB_BITS-1:0];
`endif
          if (idx_q == LAST_SB) begin
            idx_d   = '0;
`ifdef CFG_CHECKSUM_EN
            // Ready stays high: the checksum word is still to come.
            state_d = ST_CHECK;
`else
            ready_d = 1'b0;
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
          end
        end else begin
          state_d = ST_SB;
        end
      end

`ifdef CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          ready_d = 1'b0;
          state_d = ST_DONE;
          if (word_in == chk_q) begin
            // Whole configuration becomes visible on the same edge.
            lut_cfg_d = shd_lut_q;
            sb_cfg_d  = shd_sb_q;
            error_d   = 1'b0;
          end else begin
            error_d   = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif

      ST_DONE: begin
        // done is then held in IDLE until the next start clears it.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ready_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign word_ready = ready_q;
  assign lut_cfg    = lut_cfg_q;
  assign sb_cfg     = sb_cfg_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CFG_CHECKSUM_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader: table of load scenarios plus
// hand-written abort and checksum sequences; per-word expected configuration
// snapshots are queued on acceptance and compared on the following cycle.
module tb_cfg_stream_loader;

  localparam int NUM_LUT  = 9;
  localparam int LUT_BITS = 33;
  localparam int NUM_SB   = 13;
  localparam int SB_BITS  = 16;
  localparam int NCFG     = 2*NUM_LUT + NUM_SB;
`ifdef CFG_CHECKSUM_EN
  localparam int NWORDS   = NCFG + 1;
  localparam int EXTRA    = 1;
`else
  localparam int NWORDS   = NCFG;
  localparam int EXTRA    = 0;
`endif
  localparam int LIMIT    = 400;

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b1;
  logic                         start = 1'b0;
  logic [31:0]                  word_in = 32'd0;
  logic                         word_valid = 1'b0;
  logic                         word_ready;
  logic [NUM_LUT*LUT_BITS-1:0]  lut_cfg;
  logic [NUM_SB*SB_BITS-1:0]    sb_cfg;
  logic                         busy;
  logic                         done;
  logic                         error;

  cfg_stream_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .lut_cfg    (lut_cfg),
    .sb_cfg     (sb_cfg),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NUM_LUT*LUT_BITS-1:0] lut;
    logic [NUM_SB*SB_BITS-1:0]   sb;
  } snap_t;

  typedef struct {
    int seed;
    int stall_at;
    int stall_len;
    int restart_at;
    int exp_done;
  } vec_t;

  snap_t       sbq[$];
  vec_t        tbl[3];
  logic [32:0] wk_lut [NUM_LUT];
  logic [15:0] wk_sb  [NUM_SB];
  logic [32:0] cm_lut [NUM_LUT];
  logic [15:0] cm_sb  [NUM_SB];
  int          errors = 0;
  int          checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0b required %0b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] gen_word(input int seed, input int k);
    if (k == 0) return 32'hA5A5_A5A5;
    if (k == 1) return 32'h0000_0001;
    if (k == NCFG - 1) return 32'hFFFF_1234;
    return {8'(seed*37 + 1), 8'(k), 8'(k*13 + seed), 8'(seed ^ k ^ 32'h5A)};
  endfunction

  function automatic void apply_word(input int k, input logic [31:0] w);
    if (k < 2*NUM_LUT) begin
      if (k % 2 == 0) wk_lut[k/2][31:0] = w;
      else            wk_lut[k/2][32]   = w[0];
    end else begin
      wk_sb[k - 2*NUM_LUT] = w[15:0];
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < NUM_LUT; i++) begin wk_lut[i] = 33'd0; cm_lut[i] = 33'd0; end
    for (int i = 0; i < NUM_SB; i++)  begin wk_sb[i]  = 16'd0; cm_sb[i]  = 16'd0; end
  endfunction

  // Expected visible outputs: the shadowed build shows the committed copy.
  function automatic snap_t visible();
    snap_t s;
    for (int i = 0; i < NUM_LUT; i++)
      s.lut[i*LUT_BITS +: LUT_BITS] = (EXTRA != 0) ? cm_lut[i] : wk_lut[i];
    for (int i = 0; i < NUM_SB; i++)
      s.sb[i*SB_BITS +: SB_BITS] = (EXTRA != 0) ? cm_sb[i] : wk_sb[i];
    return s;
  endfunction

  task automatic check_zero(input string tag);
    checkv({tag, "_lut"}, 512'(lut_cfg), 512'd0);
    checkv({tag, "_sb"},  512'(sb_cfg),  512'd0);
    check1({tag, "_busy"},  busy,       1'b0);
    check1({tag, "_done"},  done,       1'b0);
    check1({tag, "_error"}, error,      1'b0);
    check1({tag, "_ready"}, word_ready, 1'b0);
  endtask

  // One load; called and returning at 1 time unit after a rising edge.
  task automatic run_load(input int seed, input int stall_at, input int stall_len,
                          input int restart_at, input int abort_at, input bit bad_chk,
                          input int exp_done, input logic exp_err);
    int          n;
    int          k;
    int          stalled;
    bit          acc;
    bit          restarted;
    logic [31:0] w;
    logic [31:0] xs;
    snap_t       s;
    n = 0; k = 0; stalled = 0; restarted = 1'b0; xs = 32'd0;
    start = 1'b1;
    word_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    check1("ready_after_start", word_ready, 1'b1);
    check1("busy_in_load", busy, 1'b1);
    check1("done_cleared", done, 1'b0);
    while (k < NWORDS && n < LIMIT) begin
      if (k == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check_zero("abort");
        clear_model();
        sbq.delete();
        word_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_zero("idle_after_abort");
        return;
      end
      if (k < NCFG) w = gen_word(seed, k);
      else          w = bad_chk ? (xs ^ 32'd1) : xs;
      if (k == stall_at && stalled < stall_len) begin
        word_valid = 1'b0;
        word_in    = 32'hDEAD_BEEF;
        stalled++;
      end else begin
        word_valid = 1'b1;
        word_in    = w;
      end
      if (k == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      acc = word_valid && word_ready;
      if (acc) begin
        if (k < NCFG) begin
          apply_word(k, w);
          xs = xs ^ w;
        end else if (!bad_chk) begin
          cm_lut = wk_lut;
          cm_sb  = wk_sb;
        end
        sbq.push_back(visible());
      end
      @(posedge clock); #1;
      n++;
      start = 1'b0;
      if (acc) begin
        s = sbq.pop_front();
        checkv("word_lut_cfg", 512'(lut_cfg), 512'(s.lut));
        checkv("word_sb_cfg",  512'(sb_cfg),  512'(s.sb));
        k++;
      end else begin
        check1("stall_busy", busy, 1'b1);
      end
    end
    word_valid = 1'b0;
    checki("words_accepted", k, NWORDS);
    while (!done && n < LIMIT) begin
      @(posedge clock); #1;
      n++;
    end
    checki("done_cycle", n, exp_done);
    check1("busy_at_done", busy, 1'b0);
    check1("ready_at_done", word_ready, 1'b0);
    check1("error_at_done", error, exp_err);
    s = visible();
    checkv("final_lut_cfg", 512'(lut_cfg), 512'(s.lut));
    checkv("final_sb_cfg",  512'(sb_cfg),  512'(s.sb));
    @(posedge clock); #1;
    check1("done_held", done, 1'b1);
    check1("ready_idle", word_ready, 1'b0);
  endtask

  task automatic check_spec_words();
    logic [32:0] l0;
    logic [15:0] s12;
    l0  = lut_cfg[32:0];
    s12 = sb_cfg[207:192];
    checkv("lut0_value", 512'(l0),  512'(33'h1_A5A5_A5A5));
    checkv("sb12_value", 512'(s12), 512'(16'h1234));
  endtask

  initial begin
    tbl[0] = '{seed: 1, stall_at: -1, stall_len: 0, restart_at: -1, exp_done: 33};
    tbl[1] = '{seed: 2, stall_at: 10, stall_len: 5, restart_at: -1, exp_done: 38};
    tbl[2] = '{seed: 3, stall_at: -1, stall_len: 0, restart_at: 7,  exp_done: 33};
    clear_model();

    // Asynchronous reset asserted between clock edges.
    #2 reset_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check_zero("idle");

    for (int i = 0; i < 3; i++) begin
      run_load(tbl[i].seed, tbl[i].stall_at, tbl[i].stall_len, tbl[i].restart_at,
               -1, 1'b0, tbl[i].exp_done + EXTRA, 1'b0);
      check_spec_words();
    end

    // Reset pulsed after 20 accepted words, then a fresh full load.
    run_load(4, -1, 0, -1, 20, 1'b0, 0, 1'b0);
    run_load(5, -1, 0, -1, -1, 1'b0, 33 + EXTRA, 1'b0);
    check_spec_words();

`ifdef CFG_CHECKSUM_EN
    // Bad checksum keeps the prior configuration and flags error.
    run_load(6, -1, 0, -1, -1, 1'b1, 34, 1'b1);
    check_spec_words();
    run_load(7, 3, 2, -1, -1, 1'b0, 36, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Receives a fabric configuration stream as 32-bit words over a valid/ready handshake.
- Writes each word into the LUT truth-table registers and the switch-box configure registers of the fpga fabric.
- Word order matches the configuration memory file: 2 words per LUT, then 1 word per switch box.
- Gives the fabric an in-system load path in place of loading configuration directly from the bench.

Parameters:
NUM_LUT, 9, number of LUTs; each LUT takes 2 stream words
LUT_BITS, 33, LUT truth-table width; must be 33 to fit the 32+1 word packing
NUM_SB, 13, number of switch boxes; each takes 1 stream word
SB_BITS, 16, switch-box configure width; must be 16 or less

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load when idle
word_in  in  32  configuration word
word_valid  in  1  word_in is valid this cycle
word_ready  out  1  loader accepts word_in this cycle
lut_cfg  out  NUM_LUT*LUT_BITS  LUT k at bits [33k+32:33k]
sb_cfg  out  NUM_SB*SB_BITS  switch box j at bits [16j+15:16j]
busy  out  1  a load is in progress
done  out  1  last load completed; held until the next start
error  out  1  last load rejected (checksum build only; otherwise always 0)

Behaviour:
- Reset (async assert, sync release): state IDLE; lut_cfg=0, sb_cfg=0, word index=0; busy=0, done=0, error=0, word_ready=0.
- Transfer rule: a word is accepted on a clock edge where word_valid and word_ready are both 1. Exactly one word is accepted per such edge.
- word_ready is registered:
  - It is 1 in every load state.
  - It is 0 in IDLE and DONE.
  - It goes high the cycle after start.
- States and transitions:
  - IDLE: on start, go to LUT_LO with idx=0; busy=1, done=0, error=0.
  - LUT_LO: accept word, write LUT[idx] bits [31:0], go to LUT_HI.
  - LUT_HI: accept word, write LUT[idx] bit 32 from word_in[0]; word_in[31:1] is ignored. If idx=NUM_LUT-1, go to SB with idx=0; otherwise idx+1 and return to LUT_LO.
  - SB: accept word, write sb[idx] from word_in[SB_BITS-1:0]; upper bits are ignored. If idx=NUM_SB-1, go to DONE (or CHECK in the checksum build); otherwise idx+1.
  - DONE: for one cycle, busy=0 and done=1, then go to IDLE. done stays high in IDLE.
- Stall: with word_valid=0, state, index and outputs hold indefinitely. There is no timeout.
- start while busy is ignored. It does not restart the load and does not affect the index.
- A new start after done re-runs the load. Registers keep their old contents until each one is overwritten.
- Base build: each register updates on the edge that accepts its word. Output is visible the following cycle.
- Load length:
  - Base build: 2*NUM_LUT+NUM_SB words (31 at defaults).
  - With back-to-back valid, done rises 33 cycles after the start pulse: 1 cycle to raise ready, 31 words, 1 cycle in DONE.
- Reset mid-load aborts the load: all configuration registers are cleared and state returns to IDLE.
- word_in is don't-care when word_valid=0. It is don't-care when word_ready=0 regardless of X.

Optional Feature:
Macro CFG_CHECKSUM_EN.
- When defined:
  - The stream carries one extra trailing word: the XOR of all 31 configuration words.
  - Words are written to shadow registers. lut_cfg and sb_cfg continue to show the previous committed configuration during the load.
  - After the last SB word, the loader enters state CHECK and accepts the checksum word.
  - On match: all shadow registers are copied to the outputs in one cycle, done=1, error=0.
  - On mismatch: outputs are unchanged, done=1, error=1.
  - Load length is 32 words.
- When undefined: no shadow registers and no CHECK state; error is tied to 0.

Test Plan:
- Reset with reset_n=0 mid-clock (asynchronous, not on a clock edge) -> all outputs 0 immediately, word_ready=0.
- Counter bitstream, 31 words back-to-back after start:
  - LUT0 words 0xA5A5A5A5, 0x00000001 -> lut_cfg[32:0]=0x1A5A5A5A5.
  - sb12 word 0xFFFF1234 -> sb_cfg[207:192]=0x1234.
  - done=1 exactly 33 cycles after start.
- Same stream with word_valid dropped for 5 cycles after word 10 -> index holds, final config identical, done at 38 cycles.
- start pulsed again at word 7 -> ignored; load completes normally with 31 words total.
- reset_n pulsed low after word 20 -> outputs 0 and state IDLE; a fresh start with the full stream loads correctly.
- CFG_CHECKSUM_EN build:
  - Correct XOR word -> outputs commit, error=0.
  - Checksum with bit 0 flipped -> outputs keep the prior config, done=1, error=1.
